// File: rtl/systolic_skew_feeder_if.sv
// Activation vector stream into the skew feeder: one vector per beat,
// valid/ready handshake, with an end-of-frame marker.
interface systolic_skew_feeder_if #(
  parameter int PE_ARRAY_H    = 32,
  parameter int IN_DATA_WIDTH = 8
);
  logic                                    vec_vld;
  logic                                    vec_rdy;
  logic                                    vec_last;
  logic [0:PE_ARRAY_H-1][IN_DATA_WIDTH-1:0] vec_data;

  modport master (output vec_vld, output vec_last, output vec_data, input  vec_rdy);
  modport slave  (input  vec_vld, input  vec_last, input  vec_data, output vec_rdy);
endinterface

// File: rtl/systolic_skew_feeder.sv
// Row-skewing activation feeder for the systolic PE mesh. Row r of each
// accepted vector is delayed by r extra cycles so the mesh sees a diagonal
// wavefront. After the last vector of a frame the skew lines are flushed with
// zero bubbles and o_done pulses when the last row's last element is out.
module systolic_skew_feeder #(
  parameter int PE_ARRAY_H    = 32,
  parameter int IN_DATA_WIDTH = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  systolic_skew_feeder_if.slave                   vec_if,
  output logic [0:PE_ARRAY_H-1][IN_DATA_WIDTH-1:0] o_left_data,
  output logic [0:PE_ARRAY_H-1]                    o_left_vld,
  output logic                                    o_busy,
  output logic                                    o_done
);

  localparam int CNT_W = $clog2(PE_ARRAY_H);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             accept;

  // Ready depends on state alone, so there is no path from vec_vld to vec_rdy.
  assign vec_if.vec_rdy = (state_q != FLUSH);
  assign accept         = vec_if.vec_vld && vec_if.vec_rdy;
  assign o_busy         = (state_q != IDLE);
  assign o_done         = done_q;

  // Frame sequencing: stream until the last vector, then hold off input for
  // H-1 cycles while the deepest row drains; leave FLUSH on the edge that takes
  // the counter to 0, which is also when the last row's last element lands.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, STREAM: begin
        if (accept) begin
          if (vec_if.vec_last) begin
            state_d = FLUSH;
            cnt_d   = CNT_W'(PE_ARRAY_H - 1);
          end else begin
            state_d = STREAM;
          end
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, flush counter and completion pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  for (genvar r = 0; r < PE_ARRAY_H; r++) begin : g_row
    logic [r:0]                    vld_q, vld_d;
    logic [r:0][IN_DATA_WIDTH-1:0] data_q, data_d;

    // Stage 0 takes the new element (or a zero bubble); later stages shift.
    always_comb begin
      vld_d     = vld_q;
      data_d    = data_q;
      vld_d[0]  = accept;
      data_d[0] = accept ? vec_if.vec_data[r] : '0;
      for (int s = 1; s <= r; s++) begin
        vld_d[s]  = vld_q[s-1];
        data_d[s] = data_q[s-1];
      end
    end

    // Skew chain for row r: reset discards anything partially skewed.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q  <= '0;
        data_q <= '0;
      end else begin
        vld_q  <= vld_d;
        data_q <= data_d;
      end
    end

    assign o_left_vld[r]  = vld_q[r];
    assign o_left_data[r] = data_q[r];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: directed scenarios on a 4-row instance and
// randomized frames on a 32-row instance, checked against a timeline model.
`timescale 1ns/1ps
module tb_systolic_skew_feeder;

  localparam int NC = 16384;
  typedef logic [0:31][7:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_skew_feeder_if #(.PE_ARRAY_H(4),  .IN_DATA_WIDTH(8)) if4();
  systolic_skew_feeder_if #(.PE_ARRAY_H(32), .IN_DATA_WIDTH(8)) if32();

  logic [0:3][7:0]  ld4;
  logic [0:3]       lv4;
  logic             busy4, done4;
  logic [0:31][7:0] ld32;
  logic [0:31]      lv32;
  logic             busy32, done32;

  systolic_skew_feeder #(.PE_ARRAY_H(4), .IN_DATA_WIDTH(8)) dut4 (
    .clk(clk), .rst(rst), .vec_if(if4),
    .o_left_data(ld4), .o_left_vld(lv4), .o_busy(busy4), .o_done(done4)
  );

  systolic_skew_feeder #(.PE_ARRAY_H(32), .IN_DATA_WIDTH(8)) dut32 (
    .clk(clk), .rst(rst), .vec_if(if32),
    .o_left_data(ld32), .o_left_vld(lv32), .o_busy(busy32), .o_done(done32)
  );

  // Reference model: per instance, the vector accepted on each numbered edge.
  // Cycle c is the interval following edge c; row r in cycle c shows the
  // vector accepted on edge c-r. After a last-vector accept on edge L the
  // input is blocked in cycles L..L+H-2 and done shows in cycle L+H-1.
  int   cyc    [2];
  int   last_e [2];
  bit   fopen  [2];
  logic av     [2][NC];
  vec_t ad     [2][NC];

  vec_t        obs_data, exp_data;
  logic [0:31] obs_vld, exp_vld;
  logic [2:0]  obs_st, exp_st;   // {rdy, busy, done}

  int n_checks = 0;
  int n_err    = 0;

  function automatic int hof(input int k);
    return (k == 0) ? 4 : 32;
  endfunction

  function automatic bit flushing(input int k, input int c);
    return (c >= last_e[k]) && (c <= last_e[k] + hof(k) - 2);
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 32; i++) v[i] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cyc[k]    = 0;
      last_e[k] = -1000;
      fopen[k]  = 1'b0;
      for (int i = 0; i < NC; i++) av[k][i] = 1'b0;
    end
  endtask

  // Drive one cycle of stimulus on instance k, advance the model, and capture
  // both the model's expectation and the DUT's outputs for the new cycle.
  task automatic step(input int k, input logic vld, input logic last,
                      input vec_t d, output bit acc);
    int c, h, e;
    c   = cyc[k];
    h   = hof(k);
    acc = vld && !flushing(k, c);
    if (k == 0) begin
      if4.vec_vld = vld; if4.vec_last = last; if4.vec_data = d[0:3];
    end else begin
      if32.vec_vld = vld; if32.vec_last = last; if32.vec_data = d;
    end
    @(posedge clk);
    c++;
    av[k][c] = acc;
    ad[k][c] = d;
    if (acc) begin
      if (last) begin
        last_e[k] = c;
        fopen[k]  = 1'b0;
      end else begin
        fopen[k]  = 1'b1;
      end
    end
    cyc[k] = c;
    @(negedge clk);
    exp_vld  = '0;
    exp_data = '0;
    for (int r = 0; r < h; r++) begin
      e = c - r;
      if (e >= 1 && av[k][e]) begin
        exp_vld[r]  = 1'b1;
        exp_data[r] = ad[k][e][r];
      end
    end
    exp_st = {!flushing(k, c), fopen[k] || flushing(k, c), c == last_e[k] + h - 1};
    if (k == 0) begin
      obs_data = {ld4, 224'b0};
      obs_vld  = {lv4, 28'b0};
      obs_st   = {if4.vec_rdy, busy4, done4};
    end else begin
      obs_data = ld32;
      obs_vld  = lv32;
      obs_st   = {if32.vec_rdy, busy32, done32};
    end
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    if4.vec_vld  = 1'b0;
    if32.vec_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    vec_t va, vb, vc;
    bit acc;
    va = rand_vec(); vb = rand_vec(); vc = rand_vec();
    step(0, 1'b1, 1'b0, va, acc);
    step(0, 1'b1, 1'b0, vb, acc);
    n_checks++;
    if ({obs_vld, obs_data} !== {exp_vld, exp_data}) begin
      n_err++; $display("FAIL reset_prefill got=%h/%h exp=%h/%h", obs_vld, obs_data, exp_vld, exp_data);
    end
    rst = 1'b0;
    if4.vec_vld = 1'b1; if4.vec_last = 1'b0; if4.vec_data = vc[0:3];
    #1;
    n_checks++;
    if (lv4 !== 4'b0 || ld4 !== 32'b0) begin
      n_err++; $display("FAIL reset_rows got vld=%b data=%h exp 0", lv4, ld4);
    end
    n_checks++;
    if ({if4.vec_rdy, busy4, done4} !== 3'b100) begin
      n_err++; $display("FAIL reset_status got=%b exp=100", {if4.vec_rdy, busy4, done4});
    end
    @(negedge clk);
    n_checks++;
    if (lv4 !== 4'b0 || ld4 !== 32'b0 || busy4 !== 1'b0) begin
      n_err++; $display("FAIL reset_no_accept got vld=%b data=%h busy=%b exp 0", lv4, ld4, busy4);
    end
    if4.vec_vld = 1'b0;
    rst = 1'b1;
    model_reset();
    for (int c = 1; c <= 6; c++) begin
      if (c == 1) step(0, 1'b1, 1'b1, vc, acc);
      else        step(0, 1'b0, 1'b0, rand_vec(), acc);
      n_checks++;
      if ({obs_vld, obs_data} !== {exp_vld, exp_data}) begin
        n_err++; $display("FAIL reset_after_rows cyc=%0d got=%h/%h exp=%h/%h", c, obs_vld, obs_data, exp_vld, exp_data);
      end
      n_checks++;
      if (obs_st !== exp_st) begin
        n_err++; $display("FAIL reset_after_status cyc=%0d got=%b exp=%b", c, obs_st, exp_st);
      end
      if (c == 1) begin
        n_checks++;
        if (obs_vld[0] !== 1'b1 || obs_data[0] !== vc[0]) begin
          n_err++; $display("FAIL reset_first_accept got=%b/%h exp=1/%h", obs_vld[0], obs_data[0], vc[0]);
        end
      end
    end
  endtask

  task automatic test_single();
    vec_t v;
    bit acc;
    reset_dut();
    v = '0;
    v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33; v[3] = 8'h44;
    for (int c = 1; c <= 6; c++) begin
      if (c == 1) step(0, 1'b1, 1'b1, v, acc);
      else        step(0, 1'b0, 1'($urandom_range(0, 1)), rand_vec(), acc);
      n_checks++;
      if ({obs_vld, obs_data} !== {exp_vld, exp_data}) begin
        n_err++; $display("FAIL single_rows cyc=%0d got=%h/%h exp=%h/%h", c, obs_vld, obs_data, exp_vld, exp_data);
      end
      if (c <= 4) begin
        n_checks++;
        if (obs_vld[c-1] !== 1'b1 || obs_data[c-1] !== v[c-1]) begin
          n_err++; $display("FAIL single_row%0d cyc=%0d got=%b/%h exp=1/%h", c-1, c, obs_vld[c-1], obs_data[c-1], v[c-1]);
        end
      end
      n_checks++;
      if (obs_st[0] !== (c == 4) || obs_st[2] !== !(c >= 1 && c <= 3)) begin
        n_err++; $display("FAIL single_rdy_done cyc=%0d got rdy=%b done=%b exp rdy=%b done=%b",
                          c, obs_st[2], obs_st[0], !(c <= 3), (c == 4));
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t vs [3];
    bit acc;
    reset_dut();
    for (int i = 0; i < 3; i++) vs[i] = rand_vec();
    for (int c = 1; c <= 8; c++) begin
      if (c <= 3) step(0, 1'b1, 1'(c == 3), vs[c-1], acc);
      else        step(0, 1'b0, 1'b0, rand_vec(), acc);
      n_checks++;
      if ({obs_vld, obs_data} !== {exp_vld, exp_data}) begin
        n_err++; $display("FAIL b2b_rows cyc=%0d got=%h/%h exp=%h/%h", c, obs_vld, obs_data, exp_vld, exp_data);
      end
      n_checks++;
      if (obs_st !== exp_st) begin
        n_err++; $display("FAIL b2b_status cyc=%0d got=%b exp=%b", c, obs_st, exp_st);
      end
      if (c >= 4 && c <= 6) begin
        n_checks++;
        if (obs_vld[3] !== 1'b1 || obs_data[3] !== vs[c-4][3]) begin
          n_err++; $display("FAIL b2b_row3 cyc=%0d got=%b/%h exp=1/%h", c, obs_vld[3], obs_data[3], vs[c-4][3]);
        end
      end
      n_checks++;
      if (obs_st[0] !== (c == 6)) begin
        n_err++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", c, obs_st[0], (c == 6));
      end
    end
  endtask

  task automatic test_bubble();
    vec_t va, vb;
    bit acc;
    reset_dut();
    va = rand_vec(); vb = rand_vec();
    for (int c = 1; c <= 8; c++) begin
      if (c == 1)      step(0, 1'b1, 1'b0, va, acc);
      else if (c == 2) step(0, 1'b0, 1'b1, rand_vec(), acc);
      else if (c == 3) step(0, 1'b1, 1'b1, vb, acc);
      else             step(0, 1'b0, 1'b0, rand_vec(), acc);
      n_checks++;
      if ({obs_vld, obs_data} !== {exp_vld, exp_data}) begin
        n_err++; $display("FAIL bubble_rows cyc=%0d got=%h/%h exp=%h/%h", c, obs_vld, obs_data, exp_vld, exp_data);
      end
      n_checks++;
      if (obs_st !== exp_st) begin
        n_err++; $display("FAIL bubble_status cyc=%0d got=%b exp=%b", c, obs_st, exp_st);
      end
      for (int r = 0; r < 4; r++) begin
        if (c == r + 2) begin
          n_checks++;
          if (obs_vld[r] !== 1'b0 || obs_data[r] !== 8'h00) begin
            n_err++; $display("FAIL bubble_gap row=%0d cyc=%0d got=%b/%h exp=0/00", r, c, obs_vld[r], obs_data[r]);
          end
        end
        if (c == r + 3) begin
          n_checks++;
          if (obs_vld[r] !== 1'b1 || obs_data[r] !== vb[r]) begin
            n_err++; $display("FAIL bubble_b row=%0d cyc=%0d got=%b/%h exp=1/%h", r, c, obs_vld[r], obs_data[r], vb[r]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    vec_t va, vn;
    bit acc, got;
    int seen, seen_cyc;
    reset_dut();
    va = rand_vec(); vn = rand_vec();
    got = 1'b0; seen = 0; seen_cyc = -1;
    for (int c = 1; c <= 12; c++) begin
      if (c == 1)    step(0, 1'b1, 1'b1, va, acc);
      else if (!got) begin
        step(0, 1'b1, 1'b1, vn, acc);
        got = acc;
      end else       step(0, 1'b0, 1'b0, rand_vec(), acc);
      n_checks++;
      if ({obs_vld, obs_data} !== {exp_vld, exp_data}) begin
        n_err++; $display("FAIL bp_rows cyc=%0d got=%h/%h exp=%h/%h", c, obs_vld, obs_data, exp_vld, exp_data);
      end
      n_checks++;
      if (obs_st !== exp_st) begin
        n_err++; $display("FAIL bp_status cyc=%0d got=%b exp=%b", c, obs_st, exp_st);
      end
      if (c >= 2 && obs_vld[0] === 1'b1) begin
        seen++;
        seen_cyc = c;
      end
    end
    n_checks++;
    if (seen !== 1 || seen_cyc !== 5) begin
      n_err++; $display("FAIL bp_accept_once got count=%0d cyc=%0d exp count=1 cyc=5", seen, seen_cyc);
    end
  endtask

  task automatic test_random();
    localparam int NFRAMES = 20;
    localparam int LIMIT   = 12000;
    int   f, i, n, gap, done_cnt, cycles;
    bit   acc, drove, finished;
    vec_t cur;
    reset_dut();
    f = 0; i = 0; n = $urandom_range(1, 50); gap = 0;
    done_cnt = 0; cycles = 0; finished = 1'b0;
    cur = rand_vec();
    while (!finished && cycles < LIMIT) begin
      drove = 1'b0;
      if (f == NFRAMES) begin
        step(1, 1'b0, 1'($urandom_range(0, 1)), rand_vec(), acc);
      end else if (gap > 0) begin
        step(1, 1'b0, 1'($urandom_range(0, 1)), rand_vec(), acc);
        gap--;
      end else begin
        step(1, 1'b1, 1'(i == n - 1), cur, acc);
        drove = 1'b1;
      end
      cycles++;
      if (drove && acc) begin
        i++;
        cur = rand_vec();
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        if (i == n) begin
          f++;
          i = 0;
          n = $urandom_range(1, 50);
        end
      end
      n_checks++;
      if ({obs_vld, obs_data} !== {exp_vld, exp_data}) begin
        n_err++; $display("FAIL rand_rows cyc=%0d got=%h/%h exp=%h/%h", cyc[1], obs_vld, obs_data, exp_vld, exp_data);
      end
      n_checks++;
      if (obs_st !== exp_st) begin
        n_err++; $display("FAIL rand_status cyc=%0d got=%b exp=%b", cyc[1], obs_st, exp_st);
      end
      if (obs_st[0] === 1'b1) done_cnt++;
      if (f == NFRAMES && cyc[1] >= last_e[1] + 33) finished = 1'b1;
    end
    n_checks++;
    if (!finished) begin
      n_err++; $display("FAIL rand_timeout got frames=%0d after %0d cycles exp=%0d", f, cycles, NFRAMES);
    end
    n_checks++;
    if (done_cnt !== NFRAMES) begin
      n_err++; $display("FAIL rand_done_count got=%0d exp=%0d", done_cnt, NFRAMES);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    if4.vec_vld  = 1'b0; if4.vec_last  = 1'b0; if4.vec_data  = '0;
    if32.vec_vld = 1'b0; if32.vec_last = 1'b0; if32.vec_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_bubble();
    test_backpressure();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
